banco_registradores: RTL and testbench

//  8-entry x LARGURA-bit register bank; directly upstream of the 8:1 datapath multiplexer.

---
 rtl/banco_registradores.sv | 97 +++++++++
 tb/tb_banco_registradores.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores.sv
// Eight-entry register bank feeding the 8:1 datapath mux.
// It takes single-cycle write, copy and increment ops and runs an 8-cycle clear sweep on request.
module banco_registradores #(
    parameter int                 LARGURA       = 16,
    parameter logic [LARGURA-1:0] VALOR_LIMPEZA = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valida,
    output logic               op_pronta,
    input  logic [1:0]         operacao,
    input  logic [2:0]         endereco,
    input  logic [2:0]         origem,
    input  logic [LARGURA-1:0] dado,
    input  logic               limpar,
    output logic               ocupado,
    output logic [2:0]         controle,
    output logic [LARGURA-1:0] registrador0,
    output logic [LARGURA-1:0] registrador1,
    output logic [LARGURA-1:0] registrador2,
    output logic [LARGURA-1:0] registrador3,
    output logic [LARGURA-1:0] registrador4,
    output logic [LARGURA-1:0] registrador5,
    output logic [LARGURA-1:0] registrador6,
    output logic [LARGURA-1:0] registrador7
);

    typedef enum logic {OCIOSO, LIMPANDO} estado_t;

    localparam logic [1:0] OP_ESCRITA = 2'b00;
    localparam logic [1:0] OP_COPIA   = 2'b01;
    localparam logic [1:0] OP_INCR    = 2'b10;

    estado_t                  estado, prox_estado;
    logic [7:0][LARGURA-1:0]  regs;
    logic [2:0]               cnt;
    logic                     aceita;

    // A clear request wins over a concurrent op, so it also blocks op_pronta.
    assign op_pronta = (estado == OCIOSO) && !limpar;
    assign aceita    = op_valida && op_pronta;
    assign ocupado   = (estado == LIMPANDO);

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (limpar)      prox_estado = LIMPANDO;
            LIMPANDO: if (cnt == 3'd7) prox_estado = OCIOSO;
            default:                   prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs     <= '0;
            controle <= '0;
            cnt      <= '0;
        end else if (estado == LIMPANDO) begin
            regs[cnt] <= VALOR_LIMPEZA;
            controle  <= cnt;
            cnt       <= cnt + 3'd1;
        end else if (limpar) begin
            cnt <= '0;
        end else if (aceita) begin
            case (operacao)
                OP_ESCRITA: begin
                    regs[endereco] <= dado;
                    controle       <= endereco;
                end
                OP_COPIA: begin
                    regs[endereco] <= regs[origem];
                    controle       <= endereco;
                end
                OP_INCR: begin
                    regs[endereco] <= regs[endereco] + LARGURA'(1);
                    controle       <= endereco;
                end
                default: ;
            endcase
        end
    end

    assign registrador0 = regs[0];
    assign registrador1 = regs[1];
    assign registrador2 = regs[2];
    assign registrador3 = regs[3];
    assign registrador4 = regs[4];
    assign registrador5 = regs[5];
    assign registrador6 = regs[6];
    assign registrador7 = regs[7];

endmodule

// File: tb/tb_banco_registradores.sv
// Directed self-checking bench for banco_registradores.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_banco_registradores;

    localparam int LARGURA = 16;
    localparam logic [LARGURA-1:0] LIMPO = 16'h00FF;

    logic               clock = 1'b0;
    logic               reset, op_valida, limpar;
    logic [1:0]         operacao;
    logic [2:0]         endereco, origem;
    logic [LARGURA-1:0] dado;
    logic               op_pronta, ocupado;
    logic [2:0]         controle;
    logic [LARGURA-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [LARGURA-1:0] r [8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    banco_registradores #(.LARGURA(LARGURA), .VALOR_LIMPEZA(LIMPO)) dut (
        .clock(clock), .reset(reset), .op_valida(op_valida), .op_pronta(op_pronta),
        .operacao(operacao), .endereco(endereco), .origem(origem), .dado(dado),
        .limpar(limpar), .ocupado(ocupado), .controle(controle),
        .registrador0(r0), .registrador1(r1), .registrador2(r2), .registrador3(r3),
        .registrador4(r4), .registrador5(r5), .registrador6(r6), .registrador7(r7)
    );

    assign r[0] = r0; assign r[1] = r1; assign r[2] = r2; assign r[3] = r3;
    assign r[4] = r4; assign r[5] = r5; assign r[6] = r6; assign r[7] = r7;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [2:0] e, input logic [2:0] o,
                         input logic [LARGURA-1:0] d);
        op_valida = 1'b1; operacao = op; endereco = e; origem = o; dado = d;
        tick();
        op_valida = 1'b0; operacao = 2'b11;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (r[i] !== 16'h0000) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h expected 0000", i, r[i]);
            end
        end
        n_checks++;
        if (controle !== 3'd0) begin n_fail++; $display("FAIL reset_controle: got %0d expected 0", controle); end
        n_checks++;
        if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
        n_checks++;
        if (op_pronta !== 1'b1) begin n_fail++; $display("FAIL reset_op_pronta: got %b expected 1", op_pronta); end
    endtask

    task automatic test_write_copy();
        do_op(2'b00, 3'd3, 3'd0, 16'hA5A5);
        n_checks++;
        if (r3 !== 16'hA5A5) begin n_fail++; $display("FAIL write_reg3: got %h expected a5a5", r3); end
        n_checks++;
        if (controle !== 3'd3) begin n_fail++; $display("FAIL write_controle: got %0d expected 3", controle); end
        do_op(2'b01, 3'd6, 3'd3, 16'h0000);
        n_checks++;
        if (r6 !== 16'hA5A5) begin n_fail++; $display("FAIL copy_reg6: got %h expected a5a5", r6); end
        n_checks++;
        if (controle !== 3'd6) begin n_fail++; $display("FAIL copy_controle: got %0d expected 6", controle); end
        do_op(2'b01, 3'd3, 3'd3, 16'h0000);
        n_checks++;
        if (r3 !== 16'hA5A5) begin n_fail++; $display("FAIL copy_self: got %h expected a5a5", r3); end
        do_op(2'b11, 3'd1, 3'd0, 16'h1111);
        n_checks++;
        if (controle !== 3'd3 || r1 !== 16'h0000) begin
            n_fail++; $display("FAIL noop: controle %0d reg1 %h expected 3 / 0000", controle, r1);
        end
    endtask

    task automatic test_increment_wrap();
        do_op(2'b00, 3'd5, 3'd0, 16'hFFFF);
        do_op(2'b10, 3'd5, 3'd0, 16'h0000);
        n_checks++;
        if (r5 !== 16'h0000) begin n_fail++; $display("FAIL incr_wrap: got %h expected 0000", r5); end
        n_checks++;
        if (controle !== 3'd5) begin n_fail++; $display("FAIL incr_controle: got %0d expected 5", controle); end
        do_op(2'b10, 3'd5, 3'd0, 16'h0000);
        n_checks++;
        if (r5 !== 16'h0001) begin n_fail++; $display("FAIL incr_second: got %h expected 0001", r5); end
    endtask

    task automatic test_clear_sweep();
        int busy;
        for (int i = 0; i < 8; i++) do_op(2'b00, 3'(i), 3'd0, 16'h1000 + 16'(i));
        limpar = 1'b1; op_valida = 1'b1; operacao = 2'b00; endereco = 3'd2; dado = 16'hDEAD;
        #1;
        n_checks++;
        if (op_pronta !== 1'b0) begin n_fail++; $display("FAIL clear_blocks_pronta: got %b expected 0", op_pronta); end
        tick();
        limpar = 1'b0; op_valida = 1'b0; operacao = 2'b11;
        n_checks++;
        if (r2 !== 16'h1002) begin n_fail++; $display("FAIL clear_op_ignored: got %h expected 1002", r2); end
        busy = (ocupado === 1'b1) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (controle !== 3'(k) || r[k] !== LIMPO) begin
                n_fail++;
                $display("FAIL sweep_step%0d: controle %0d reg %h expected %0d / 00ff", k, controle, r[k], k);
            end
            if (ocupado === 1'b1) busy++;
        end
        n_checks++;
        if (busy != 8) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d expected 8", busy); end
        n_checks++;
        if (op_pronta !== 1'b1 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL sweep_end: op_pronta %b ocupado %b expected 1 / 0", op_pronta, ocupado);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (r[i] !== LIMPO) begin n_fail++; $display("FAIL sweep_final_reg%0d: got %h expected 00ff", i, r[i]); end
        end
    endtask

    task automatic test_handshake_stall();
        int waited;
        do_op(2'b00, 3'd4, 3'd0, 16'h1234);
        limpar = 1'b1; op_valida = 1'b1; operacao = 2'b10; endereco = 3'd4;
        tick();
        limpar = 1'b0;
        waited = 0;
        while (op_pronta !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 8) begin n_fail++; $display("FAIL stall_wait: waited %0d expected 8", waited); end
        n_checks++;
        if (r4 !== LIMPO) begin n_fail++; $display("FAIL stall_not_early: got %h expected 00ff", r4); end
        tick();
        op_valida = 1'b0; operacao = 2'b11;
        n_checks++;
        if (r4 !== 16'h0100 || controle !== 3'd4) begin
            n_fail++; $display("FAIL stall_applied: reg4 %h controle %0d expected 0100 / 4", r4, controle);
        end
        tick(); tick();
        n_checks++;
        if (r4 !== 16'h0100) begin n_fail++; $display("FAIL stall_once: got %h expected 0100", r4); end
    endtask

    task automatic test_reset_mid_sweep();
        do_op(2'b00, 3'd7, 3'd0, 16'hBEEF);
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (ocupado !== 1'b0 || controle !== 3'd0 || op_pronta !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ctrl: ocupado %b controle %0d op_pronta %b expected 0 / 0 / 1", ocupado, controle, op_pronta);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (r[i] !== 16'h0000) begin n_fail++; $display("FAIL midreset_reg%0d: got %h expected 0000", i, r[i]); end
        end
        tick(); tick(); tick();
        n_checks++;
        if (ocupado !== 1'b0 || r7 !== 16'h0000 || controle !== 3'd0) begin
            n_fail++; $display("FAIL midreset_idle: ocupado %b reg7 %h controle %0d expected 0 / 0000 / 0", ocupado, r7, controle);
        end
    endtask

    initial begin
        reset = 1'b1; op_valida = 1'b0; limpar = 1'b0;
        operacao = 2'b11; endereco = '0; origem = '0; dado = '0;
        #1;
        test_reset();
        test_write_copy();
        test_increment_wrap();
        test_clear_sweep();
        test_handshake_stall();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
